// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode constants and
// the pointer/count width derived from a depth.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Address bits plus one wrap bit, so a full FIFO is distinguishable from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 8
);
    localparam int PTR_WIDTH = ptr_width(MEM_DEPTH);

    logic                  i_winc;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_rinc;
    logic                  i_clr_err;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_afull;
    logic                  o_aempty;
    logic [PTR_WIDTH-1:0]  o_count;
    logic                  o_ovf;
    logic                  o_udf;

    modport master (
        output i_winc, i_wdata, i_rinc, i_clr_err,
        input  o_rdata, o_full, o_empty, o_afull, o_aempty, o_count, o_ovf, o_udf
    );

    modport slave (
        input  i_winc, i_wdata, i_rinc, i_clr_err,
        output o_rdata, o_full, o_empty, o_afull, o_aempty, o_count, o_ovf, o_udf
    );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, combinational read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags, sticky
// overflow/underflow errors and selectable registered or fall-through read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 8,
    parameter int AF_LEVEL   = MEM_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic              i_clk,
    input  logic              i_rst,
    param_sync_fifo_if.slave  bus
);

    localparam int PTR_WIDTH = ptr_width(MEM_DEPTH);
    localparam int AW        = PTR_WIDTH - 1;

    if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("param_sync_fifo: MEM_DEPTH must be a power of 2 and at least 2");
    end
    if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= MEM_DEPTH))) begin : g_bad_levels
        $error("param_sync_fifo: need 0 < AE_LEVEL < AF_LEVEL <= MEM_DEPTH");
    end

    logic [PTR_WIDTH-1:0]  wptr;
    logic [PTR_WIDTH-1:0]  rptr;
    logic [PTR_WIDTH-1:0]  count;
    logic [PTR_WIDTH-1:0]  count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Acceptance uses the registered flags, so same-cycle traffic on the other
    // side never rescues a write into a full or a read from an empty FIFO.
    assign wr_en     = bus.i_winc & ~full_q;
    assign rd_en     = bus.i_rinc & ~empty_q;
    assign count_nxt = count + PTR_WIDTH'(wr_en) - PTR_WIDTH'(rd_en);

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.i_wdata),
        .raddr (rptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            count    <= count_nxt;
            full_q   <= (count_nxt == PTR_WIDTH'(MEM_DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= PTR_WIDTH'(AF_LEVEL));
            aempty_q <= (count_nxt <= PTR_WIDTH'(AE_LEVEL));
            // Set has priority over clear.
            ovf_q    <= (bus.i_winc & full_q)  | (ovf_q & ~bus.i_clr_err);
            udf_q    <= (bus.i_rinc & empty_q) | (udf_q & ~bus.i_clr_err);
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is shown directly; forced to zero while empty so the
        // unreset array never leaks onto the output.
        assign bus.o_rdata = empty_q ? '0 : mem_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_q;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rdata_q <= '0;
            end else if (rd_en) begin
                rdata_q <= mem_rdata;
            end
        end
        assign bus.o_rdata = rdata_q;
    end

    assign bus.o_full   = full_q;
    assign bus.o_empty  = empty_q;
    assign bus.o_afull  = afull_q;
    assign bus.o_aempty = aempty_q;
    assign bus.o_count  = count;
    assign bus.o_ovf    = ovf_q;
    assign bus.o_udf    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a registered-read and a fall-through instance checked
// every cycle against queue-based models, plus hand-computed directed expectations.
module tb_param_sync_fifo;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int D  = 8;
    localparam int AF = D - 2;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(DW), .MEM_DEPTH(D)) bs ();
    param_sync_fifo_if #(.DATA_WIDTH(DW), .MEM_DEPTH(D)) bf ();

    param_sync_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(D), .FWFT(FIFO_STD)) u_std (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bs)
    );

    param_sync_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(D), .FWFT(FIFO_FWFT)) u_fw (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural models: contents as queues, outputs derived from queue size.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_f[$];
    logic [DW-1:0] rd_s;
    logic [DW-1:0] popped;
    bit ovf_s, udf_s, ovf_f, udf_f;
    bit mdl_ok = 0;
    bit full_m, empty_m;

    always @(posedge clk) begin
        if (rst) begin
            q_s.delete();
            rd_s  = '0;
            ovf_s = 0;
            udf_s = 0;
            mdl_ok = 1;
        end else begin
            full_m  = (q_s.size() == D);
            empty_m = (q_s.size() == 0);
            if (bs.i_rinc && !empty_m) begin
                popped = q_s.pop_front();
                rd_s = popped;
            end
            if (bs.i_winc && !full_m) q_s.push_back(bs.i_wdata);
            ovf_s = (bs.i_winc && full_m)  ? 1'b1 : (bs.i_clr_err ? 1'b0 : ovf_s);
            udf_s = (bs.i_rinc && empty_m) ? 1'b1 : (bs.i_clr_err ? 1'b0 : udf_s);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q_f.delete();
            ovf_f = 0;
            udf_f = 0;
        end else begin
            automatic bit f = (q_f.size() == D);
            automatic bit e = (q_f.size() == 0);
            if (bf.i_rinc && !e) void'(q_f.pop_front());
            if (bf.i_winc && !f) q_f.push_back(bf.i_wdata);
            ovf_f = (bf.i_winc && f) ? 1'b1 : (bf.i_clr_err ? 1'b0 : ovf_f);
            udf_f = (bf.i_rinc && e) ? 1'b1 : (bf.i_clr_err ? 1'b0 : udf_f);
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("s_count",  int'(bs.o_count),  q_s.size());
            chk("s_empty",  int'(bs.o_empty),  int'(q_s.size() == 0));
            chk("s_full",   int'(bs.o_full),   int'(q_s.size() == D));
            chk("s_afull",  int'(bs.o_afull),  int'(q_s.size() >= AF));
            chk("s_aempty", int'(bs.o_aempty), int'(q_s.size() <= AE));
            chk("s_ovf",    int'(bs.o_ovf),    int'(ovf_s));
            chk("s_udf",    int'(bs.o_udf),    int'(udf_s));
            chk("s_rdata",  int'(bs.o_rdata),  int'(rd_s));
            chk("f_count",  int'(bf.o_count),  q_f.size());
            chk("f_empty",  int'(bf.o_empty),  int'(q_f.size() == 0));
            chk("f_full",   int'(bf.o_full),   int'(q_f.size() == D));
            chk("f_afull",  int'(bf.o_afull),  int'(q_f.size() >= AF));
            chk("f_aempty", int'(bf.o_aempty), int'(q_f.size() <= AE));
            chk("f_ovf",    int'(bf.o_ovf),    int'(ovf_f));
            chk("f_udf",    int'(bf.o_udf),    int'(udf_f));
            if (q_f.size() != 0) chk("f_rdata", int'(bf.o_rdata), int'(q_f[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic op_s(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bs.i_winc = w; bs.i_wdata = d; bs.i_rinc = r; bs.i_clr_err = c;
        step();
        bs.i_winc = 0; bs.i_rinc = 0; bs.i_clr_err = 0;
    endtask

    task automatic op_f(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bf.i_winc = w; bf.i_wdata = d; bf.i_rinc = r; bf.i_clr_err = c;
        step();
        bf.i_winc = 0; bf.i_rinc = 0; bf.i_clr_err = 0;
    endtask

    initial begin
        bs.i_winc = 0; bs.i_wdata = '0; bs.i_rinc = 0; bs.i_clr_err = 0;
        bf.i_winc = 0; bf.i_wdata = '0; bf.i_rinc = 0; bf.i_clr_err = 0;
        rst = 1;
        step(); step();
        rst = 0;
        step();

        // Reset state
        chk("rst_empty",  int'(bs.o_empty),  1);
        chk("rst_aempty", int'(bs.o_aempty), 1);
        chk("rst_count",  int'(bs.o_count),  0);
        chk("rst_full",   int'(bs.o_full),   0);
        chk("rst_ovf",    int'(bs.o_ovf),    0);
        chk("rst_rdata",  int'(bs.o_rdata),  0);

        // Fill and overflow
        for (int k = 1; k <= 8; k++) begin
            op_s(1, 8'(k * 8'h11), 0, 0);
            if (k == 5) chk("fill5_afull", int'(bs.o_afull), 0);
            if (k == 6) chk("fill6_afull", int'(bs.o_afull), 1);
            if (k == 7) chk("fill7_full",  int'(bs.o_full),  0);
        end
        chk("fill8_full",  int'(bs.o_full),  1);
        chk("fill8_count", int'(bs.o_count), 8);
        op_s(1, 8'h99, 0, 0);
        chk("ovf_set",   int'(bs.o_ovf),   1);
        chk("ovf_count", int'(bs.o_count), 8);
        op_s(0, 8'h00, 0, 1);
        chk("ovf_clr", int'(bs.o_ovf), 0);

        // Drain and underflow
        for (int k = 1; k <= 8; k++) begin
            op_s(0, 8'h00, 1, 0);
            chk("drain_rdata", int'(bs.o_rdata), k * 8'h11);
        end
        chk("drain_empty", int'(bs.o_empty), 1);
        op_s(0, 8'h00, 1, 0);
        chk("udf_set",   int'(bs.o_udf),   1);
        chk("udf_rdata", int'(bs.o_rdata), 8'h88);
        op_s(0, 8'h00, 0, 1);

        // Simultaneous access at count 3
        for (int k = 1; k <= 3; k++) op_s(1, 8'(k), 0, 0);
        for (int k = 0; k < 5; k++) begin
            op_s(1, 8'(8'h10 + k), 1, 0);
            chk("simul_count", int'(bs.o_count), 3);
        end
        chk("simul_last_rd", int'(bs.o_rdata), 8'h11);
        for (int k = 0; k < 3; k++) begin
            op_s(0, 8'h00, 1, 0);
            chk("simul_order", int'(bs.o_rdata), 8'h12 + k);
        end

        // Simultaneous access when full
        for (int k = 1; k <= 8; k++) op_s(1, 8'(8'h20 + k), 0, 0);
        op_s(1, 8'hEE, 1, 0);
        chk("full_rw_count", int'(bs.o_count), 7);
        chk("full_rw_ovf",   int'(bs.o_ovf),   1);
        chk("full_rw_rdata", int'(bs.o_rdata), 8'h21);
        op_s(0, 8'h00, 0, 1);
        for (int k = 0; k < 7; k++) op_s(0, 8'h00, 1, 0);
        chk("full_rw_tail", int'(bs.o_rdata), 8'h28);

        // Streaming with pointer wrap
        for (int k = 0; k < 19; k++) op_s(1, 8'(8'h40 + k), (k >= 2), 0);
        for (int k = 0; k < 2; k++) op_s(0, 8'h00, 1, 0);
        chk("stream_last", int'(bs.o_rdata), 8'h52);
        chk("stream_empty", int'(bs.o_empty), 1);

        // Reset mid-operation
        for (int k = 0; k < 5; k++) op_s(1, 8'(8'h60 + k), 0, 0);
        op_s(0, 8'h00, 1, 0);
        rst = 1;
        step();
        rst = 0;
        chk("midrst_count", int'(bs.o_count), 0);
        chk("midrst_empty", int'(bs.o_empty), 1);
        chk("midrst_rdata", int'(bs.o_rdata), 0);
        step();

        // Fall-through instance
        op_f(1, 8'hA5, 0, 0);
        chk("fwft_empty", int'(bf.o_empty), 0);
        chk("fwft_rdata", int'(bf.o_rdata), 8'hA5);
        op_f(0, 8'h00, 1, 0);
        chk("fwft_pop_empty", int'(bf.o_empty), 1);
        chk("fwft_pop_count", int'(bf.o_count), 0);
        for (int k = 0; k < 4; k++) op_f(1, 8'(8'hB0 + k), 0, 0);
        op_f(1, 8'hC0, 1, 0);
        chk("fwft_head", int'(bf.o_rdata), 8'hB1);
        for (int k = 0; k < 4; k++) op_f(0, 8'h00, 1, 0);
        op_f(0, 8'h00, 1, 0);
        chk("fwft_udf", int'(bf.o_udf), 1);
        op_f(0, 8'h00, 0, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
